rvv_lane_seq: RTL and testbench

RVV_LANE_SEQ -- requirements
Module: rvv_lane_seq

---
 rtl/rvv_lane_seq.sv | 82 ++++++++
 tb/tb_rvv_lane_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rvv_lane_seq.sv
// rvv_lane_seq: sequences a vector command through a narrow ALU one lane chunk per cycle,
// assembling each chunk result into the destination vector.
module rvv_lane_seq #(
  parameter int unsigned VLEN = 10'd128,
  parameter int unsigned LANE_WIDTH = 3'b011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      vl,
  input  logic [2:0]      vsew,
  input  logic [63:0]     alu_vd,
  output logic            alu_run,
  output logic [9:0]      alu_index,
  output logic [3:0]      alu_in_reg_offset,
  output logic [VLEN-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int LW = 1 << LANE_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [15:0] ew, bits;
  logic [2:0] sh;
  logic [3:0] cm, cmask;
  logic [9:0] last_idx;
  logic illegal;
  always_comb begin
    ew = 16'd8 << vsew[1:0];
    bits = 16'(vl) * ew;
    sh = 3'(vsew[1:0]) + 3'd3 - 3'(LANE_WIDTH);
    cm = 4'((8'd1 << sh) - 8'd1);
    illegal = vsew > 3'd3 || ({1'b0, vsew} + 4'd3) < 4'(LANE_WIDTH) || bits > 16'(VLEN);
  end
  assign busy = state == RUN;
  // Chunks of consecutive elements are contiguous, so the index simply steps by LW
  // and the command ends when it reaches the last chunk position.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      alu_run <= 1'b0;
      alu_index <= '0;
      alu_in_reg_offset <= '0;
      result <= '0;
      done <= 1'b0;
      err <= 1'b0;
      last_idx <= '0;
      cmask <= '0;
    end else case (state)
      RUN: begin
        result[alu_index +: LW] <= alu_vd[LW-1:0];
        if (alu_index == last_idx) begin
          state <= DONE;
          alu_run <= 1'b0;
          alu_index <= '0;
          alu_in_reg_offset <= '0;
          done <= 1'b1;
        end else begin
          alu_index <= alu_index + 10'(LW);
          alu_in_reg_offset <= (alu_in_reg_offset + 4'd1) & cmask;
        end
      end
      default: begin
        state <= IDLE;
        done <= 1'b0;
        err <= 1'b0;
        if (start && illegal) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b1;
        end else if (start) begin
          result <= '0;
          last_idx <= 10'(bits - 16'(LW));
          cmask <= cm;
          state <= vl == 8'd0 ? DONE : RUN;
          done <= vl == 8'd0;
          alu_run <= vl != 8'd0;
        end
      end
    endcase
endmodule

// File: tb/tb_rvv_lane_seq.sv
// tb_rvv_lane_seq: directed vector table plus hand-written reset and back-to-back sequences.
module tb_rvv_lane_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] vl = '0;
  logic [2:0] vsew = '0;
  logic [63:0] alu_vd;
  logic alu_run, busy, done, err;
  logic [9:0] alu_index;
  logic [3:0] alu_in_reg_offset;
  logic [127:0] result;
  bit mode = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign alu_vd = mode ? 64'(alu_index >> 3) : 64'hA5;
  rvv_lane_seq dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .vsew(vsew), .alu_vd(alu_vd),
    .alu_run(alu_run), .alu_index(alu_index), .alu_in_reg_offset(alu_in_reg_offset),
    .result(result), .busy(busy), .done(done), .err(err)
  );
  typedef struct {
    logic [2:0] vsew;
    logic [7:0] vl;
    bit mode;
    int n;
    bit err;
    logic [127:0] res;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run_cmd(input logic [2:0] s, input logic [7:0] l, output int n, output bit d,
                         output bit e, output int dc);
    int c_per;
    c_per = s <= 3'd3 ? (1 << s) : 1;
    start = 1'b1; vsew = s; vl = l;
    @(negedge clk);
    start = 1'b0;
    n = 0; d = 1'b0; e = 1'b0; dc = -1;
    for (int c = 0; c < 40 && !d; c++) begin
      if (c > 0) @(negedge clk);
      if (alu_run) begin
        chk($sformatf("index[%0d]", n), 128'(alu_index), 128'(n * 8));
        chk($sformatf("offset[%0d]", n), 128'(alu_in_reg_offset), 128'(n % c_per));
        n++;
      end
      if (done) begin d = 1'b1; e = err; dc = c; end
    end
  endtask
  initial begin
    int n, dc, cnt;
    bit d, e;
    v[0] = '{3'd0, 8'd4,  1'b0, 4,  1'b0, 128'hA5A5A5A5};
    v[1] = '{3'd2, 8'd2,  1'b1, 8,  1'b0, 128'h0706050403020100};
    v[2] = '{3'd3, 8'd3,  1'b1, 0,  1'b1, 128'h0706050403020100};
    v[3] = '{3'd1, 8'd0,  1'b0, 0,  1'b0, 128'h0};
    v[4] = '{3'd4, 8'd1,  1'b0, 0,  1'b1, 128'h0};
    v[5] = '{3'd3, 8'd2,  1'b1, 16, 1'b0, 128'h0F0E0D0C0B0A09080706050403020100};
    v[6] = '{3'd0, 8'd16, 1'b0, 16, 1'b0, {16{8'hA5}}};
    v[7] = '{3'd0, 8'd17, 1'b0, 0,  1'b1, {16{8'hA5}}};
    v[8] = '{3'd1, 8'd3,  1'b1, 6,  1'b0, 128'h050403020100};
    @(negedge clk); @(negedge clk);
    chk("rst_run", 128'(alu_run), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_err", 128'(err), 0);
    chk("rst_index", 128'(alu_index), 0);
    chk("rst_offset", 128'(alu_in_reg_offset), 0);
    chk("rst_result", result, 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mode = v[i].mode;
      run_cmd(v[i].vsew, v[i].vl, n, d, e, dc);
      chk($sformatf("v%0d_cycles", i), 128'(n), 128'(v[i].n));
      chk($sformatf("v%0d_done", i), 128'(d), 1);
      chk($sformatf("v%0d_latency", i), 128'(dc), 128'(v[i].n));
      chk($sformatf("v%0d_err", i), 128'(e), 128'(v[i].err));
      chk($sformatf("v%0d_result", i), result, v[i].res);
    end
    @(negedge clk);
    chk("done_pulse", 128'(done), 0);
    chk("err_idle", 128'(err), 0);
    // reset in the fifth run cycle of a 16-element command
    mode = 1'b0;
    start = 1'b1; vsew = 3'd0; vl = 8'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 128'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_run", 128'(alu_run), 0);
    chk("arst_busy", 128'(busy), 0);
    chk("arst_index", 128'(alu_index), 0);
    chk("arst_result", result, 0);
    chk("arst_done", 128'(done), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || alu_run) cnt++;
    end
    chk("no_done_after_rst", 128'(cnt), 0);
    run_cmd(3'd0, 8'd4, n, d, e, dc);
    chk("post_rst_cycles", 128'(n), 4);
    chk("post_rst_result", result, 128'hA5A5A5A5);
    // start during RUN is ignored, start in DONE is taken back-to-back
    @(negedge clk);
    start = 1'b1; vsew = 3'd0; vl = 8'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0; d = 1'b0;
    for (int c = 0; c < 30 && !d; c++) begin
      if (c > 0) @(negedge clk);
      if (alu_run) n++;
      start = c == 1;
      vsew = c == 1 ? 3'd2 : 3'd0;
      vl = c == 1 ? 8'd2 : 8'd4;
      if (done) d = 1'b1;
    end
    chk("ign_done", 128'(d), 1);
    chk("ign_cycles", 128'(n), 4);
    mode = 1'b1;
    start = 1'b1; vsew = 3'd0; vl = 8'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_run", 128'(alu_run), 1);
    chk("b2b_cleared", result, 0);
    d = 1'b0;
    for (int c = 0; c < 10 && !d; c++) begin
      @(negedge clk);
      if (done) d = 1'b1;
    end
    chk("b2b_done", 128'(d), 1);
    chk("b2b_result", result, 128'h0100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
